wb_regfile: RTL and testbench

- Integer register file at the consuming end of the writeback path.
- Captures the WB-stage result (ResultW) into the architectural registers and serves the two decode-stage read ports.
- Read ports use write-first internal forwarding, so a same-cycle WB write is visible in decode.
- Adds a debug read port and a committed-write counter for bring-up and verification.

---
 rtl/wb_regfile_pkg.sv | 26 ++
 rtl/wb_regfile_rdport.sv | 29 ++
 rtl/wb_regfile.sv | 85 ++++++++
 tb/tb_wb_regfile.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared constants, types and helpers for the writeback regfile.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package wb_regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // A WB write only takes effect when enabled and not aimed at x0.
    function automatic logic wb_commit(input logic we, input reg_addr_t rd);
        return we && (rd != REG_ZERO);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_regfile_rdport.sv
// ============================================================================
// Module      : wb_regfile_rdport
// Description : Decode read port with write-first forwarding from WB.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_regfile_rdport
    import wb_regfile_pkg::*;
(
    input  logic      rst_n,
    input  reg_addr_t addr,
    input  xlen_t     stored,
    input  logic      RegWriteW,
    input  reg_addr_t RdW,
    input  xlen_t     ResultW,
    output xlen_t     rdata
);

    logic w_fwd;

    always_comb begin
        w_fwd = rst_n && wb_commit(RegWriteW, RdW) && (RdW == addr);
        rdata = w_fwd ? ResultW : stored;
    end

endmodule

`default_nettype wire

// File: rtl/wb_regfile.sv
// ============================================================================
// Module      : wb_regfile
// Description : Integer register file fed by WB, two forwarded decode ports,
//               an unforwarded debug port and a committed-write counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RegWriteW,
    input  reg_addr_t        RdW,
    input  xlen_t            ResultW,
    input  reg_addr_t        Rs1D,
    input  reg_addr_t        Rs2D,
    output xlen_t            RD1D,
    output xlen_t            RD2D,
    input  reg_addr_t        DbgAddr,
    output xlen_t            DbgData,
    output logic [CNT_W-1:0] WbCount
);

    xlen_t            regs_q [NUM_REGS];
    xlen_t            regs_d [NUM_REGS];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             w_commit;

    reg_addr_t        w_rs    [2];
    xlen_t            w_rdata [2];

    always_comb begin
        w_commit = wb_commit(RegWriteW, RdW);
        regs_d   = regs_q;
        count_d  = count_q;
        if (w_commit) begin
            regs_d[RdW] = ResultW;
            count_d     = count_q + CNT_W'(1);
        end
        // x0 is never stored, so its read value stays zero everywhere.
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    assign w_rs[0] = Rs1D;
    assign w_rs[1] = Rs2D;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rdport
            wb_regfile_rdport u_rdport (
                .rst_n     (rst_n),
                .addr      (w_rs[p]),
                .stored    (regs_q[w_rs[p]]),
                .RegWriteW (RegWriteW),
                .RdW       (RdW),
                .ResultW   (ResultW),
                .rdata     (w_rdata[p])
            );
        end
    endgenerate

    assign RD1D    = w_rdata[0];
    assign RD2D    = w_rdata[1];
    assign DbgData = regs_q[DbgAddr];
    assign WbCount = count_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_regfile.sv
// ============================================================================
// Module      : tb_wb_regfile
// Description : Directed vector bench for wb_regfile (counter width 4).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_wb_regfile;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             RegWriteW;
    logic [4:0]       RdW;
    logic [31:0]      ResultW;
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [31:0]      RD1D;
    logic [31:0]      RD2D;
    logic [4:0]       DbgAddr;
    logic [31:0]      DbgData;
    logic [CNT_W-1:0] WbCount;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RD1D      (RD1D),
        .RD2D      (RD2D),
        .DbgAddr   (DbgAddr),
        .DbgData   (DbgData),
        .WbCount   (WbCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] res;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  dbg;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ed;
        logic [3:0]  ec;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] res,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] dbg);
        RegWriteW = we;
        RdW       = rd;
        ResultW   = res;
        Rs1D      = rs1;
        Rs2D      = rs2;
        DbgAddr   = dbg;
    endtask

    initial begin
        //          we    rd      res            rs1    rs2    dbg    RD1D           RD2D           DbgData        cnt
        vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        4'd0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 4'd1};
        vecs[2]  = '{1'b1, 5'd7,  32'h1111,     5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        4'd1};
        vecs[3]  = '{1'b1, 5'd7,  32'h2222,     5'd7,  5'd7,  5'd7,  32'h2222,     32'h2222,     32'h1111,     4'd2};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  5'd7,  32'h2222,     32'hDEADBEEF, 32'h2222,     4'd3};
        vecs[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        4'd3};
        vecs[6]  = '{1'b0, 5'd9,  32'hABCD,     5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0,        4'd3};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,        5'd9,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        4'd3};
        vecs[8]  = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 5'd31, 32'hA5A5A5A5, 32'h0,        32'h0,        4'd3};
        vecs[9]  = '{1'b1, 5'd30, 32'h5A5A5A5A, 5'd31, 5'd30, 5'd30, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0,        4'd4};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        5'd30, 5'd31, 5'd31, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd5};

        rst_n = 1'b0;
        drive(1'b1, 5'd3, 32'h12345678, 5'd3, 5'd3, 5'd3);
        @(negedge clk);
        check("reset_rd1", RD1D, 32'h0);
        check("reset_rd2", RD2D, 32'h0);
        check("reset_dbg", DbgData, 32'h0);
        check("reset_cnt", 32'(WbCount), 32'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 5'd3);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].we, vecs[i].rd, vecs[i].res, vecs[i].rs1, vecs[i].rs2, vecs[i].dbg);
            @(negedge clk);
            check($sformatf("vec%0d_rd1", i), RD1D, vecs[i].e1);
            check($sformatf("vec%0d_rd2", i), RD2D, vecs[i].e2);
            check($sformatf("vec%0d_dbg", i), DbgData, vecs[i].ed);
            check($sformatf("vec%0d_cnt", i), 32'(WbCount), 32'(vecs[i].ec));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset dropped mid-cycle clears everything before the next edge.
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd30);
        @(negedge clk);
        check("pre_rst_rd1", RD1D, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd1", RD1D, 32'h0);
        check("async_rst_rd2", RD2D, 32'h0);
        check("async_rst_dbg", DbgData, 32'h0);
        check("async_rst_cnt", 32'(WbCount), 32'h0);
        drive(1'b1, 5'd5, 32'h00001234, 5'd5, 5'd5, 5'd5);
        #1;
        check("rst_nofwd_rd1", RD1D, 32'h0);
        @(posedge clk);
        #1;
        check("rst_blockwr_dbg", DbgData, 32'h0);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 5'd5);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rd1", RD1D, 32'h0);
        check("post_rst_rd2", RD2D, 32'h0);
        check("post_rst_cnt", 32'(WbCount), 32'h0);
        @(posedge clk);
        #1;

        // Counter wrap: sixteen commits to x1 with a 4-bit counter.
        for (int n = 1; n <= 16; n++) begin
            drive(1'b1, 5'd1, 32'(n), 5'd1, 5'd0, 5'd1);
            @(posedge clk);
            #1;
            if (n == 15) check("wrap_cnt15", 32'(WbCount), 32'd15);
            if (n == 16) check("wrap_cnt0", 32'(WbCount), 32'd0);
        end
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 5'd1);
        @(negedge clk);
        check("wrap_x1_val", DbgData, 32'd16);
        check("wrap_x1_rd1", RD1D, 32'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
